// File: rtl/present_pkg.sv
// Shared PRESENT definitions: nibble type, S-box tables, lookup helper and FSM state encoding.
package present_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} layer_state_e;

  // Element i holds S(i); element 0 is the rightmost nibble of the literal.
  localparam nibble_t [15:0] SboxFwd = 64'h21748FE3DA09B65C;
  localparam nibble_t [15:0] SboxInv = 64'hA970364BD21C8FE5;

  function automatic nibble_t sbox(input nibble_t x, input logic inv);
    return inv ? SboxInv[x] : SboxFwd[x];
  endfunction

  function automatic int unsigned state_bits(input int unsigned nibbles);
    return 4 * nibbles;
  endfunction

endpackage

// File: rtl/sbox_nibble.sv
// Single 4-bit PRESENT substitution, forward or inverse, purely combinational.
module sbox_nibble
  import present_pkg::*;
(
  input  nibble_t nibble_i,
  input  logic    inv_i,
  output nibble_t nibble_o
);

  assign nibble_o = sbox(nibble_i, inv_i);

endmodule

// File: rtl/sbox_layer_iter.sv
// Iterative PRESENT S-box layer: substitutes NIBBLES_PER_CYCLE nibbles per clock over a wide state,
// with valid/ready on both sides and a per-operation forward/inverse mode.
module sbox_layer_iter
  import present_pkg::*;
#(
  parameter int unsigned NIBBLES           = 16,
  parameter int unsigned NIBBLES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inv,
  input  logic [4*NIBBLES-1:0]   in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_state
);

  localparam int unsigned Steps = NIBBLES / NIBBLES_PER_CYCLE;
  localparam int unsigned Cw    = (Steps > 1) ? $clog2(Steps) : 1;

  if (NIBBLES_PER_CYCLE == 0 || (NIBBLES % NIBBLES_PER_CYCLE) != 0) begin : g_bad_npc
    $error("NIBBLES_PER_CYCLE must divide NIBBLES exactly");
  end

  layer_state_e                                 state_q;
  logic [Cw-1:0]                                step_q;
  logic                                         inv_q;
  nibble_t [Steps-1:0][NIBBLES_PER_CYCLE-1:0]   work_q;
  nibble_t [NIBBLES_PER_CYCLE-1:0]              sub_chunk;

  for (genvar i = 0; i < NIBBLES_PER_CYCLE; i++) begin : g_sbox
    sbox_nibble u_sbox (
      .nibble_i (work_q[step_q][i]),
      .inv_i    (inv_q),
      .nibble_o (sub_chunk[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      step_q    <= '0;
      inv_q     <= 1'b0;
      work_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q  <= in_state;
            inv_q   <= in_inv;
            step_q  <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          // Chunks are rewritten in place, lowest first.
          work_q[step_q] <= sub_chunk;
          if (step_q == Cw'(Steps - 1)) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_state = work_q;

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Self-checking bench for sbox_layer_iter: vector table, handshake corner cases, NPC sweep.
module tb_sbox_layer_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [63:0] in_state, out_state;

  logic        sw_valid, sw_inv;
  logic [63:0] sw_state;
  logic        sw_ir [5];
  logic        sw_ov [5];
  logic [63:0] sw_os [5];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sbox_layer_iter u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  for (genvar gi = 0; gi < 5; gi++) begin : g_sw
    sbox_layer_iter #(
      .NIBBLES           (16),
      .NIBBLES_PER_CYCLE (1 << gi)
    ) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid),
      .in_ready  (sw_ir[gi]),
      .in_inv    (sw_inv),
      .in_state  (sw_state),
      .out_valid (sw_ov[gi]),
      .out_ready (1'b1),
      .out_state (sw_os[gi])
    );
  end

  function automatic logic [3:0] ref_nib(input logic [3:0] x, input logic inv);
    if (!inv) begin
      case (x)
        4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
        4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
        4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
        4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
      endcase
    end else begin
      case (x)
        4'h0: return 4'h5; 4'h1: return 4'hE; 4'h2: return 4'hF; 4'h3: return 4'h8;
        4'h4: return 4'hC; 4'h5: return 4'h1; 4'h6: return 4'h2; 4'h7: return 4'hD;
        4'h8: return 4'hB; 4'h9: return 4'h4; 4'hA: return 4'h6; 4'hB: return 4'h3;
        4'hC: return 4'h0; 4'hD: return 4'h7; 4'hE: return 4'h9; default: return 4'hA;
      endcase
    end
  endfunction

  function automatic logic [63:0] ref_layer(input logic [63:0] s, input logic inv);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = ref_nib(s[4*i +: 4], inv);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Accept one state, then wait (bounded) for out_valid; returns latency in edges after accept.
  task automatic run_op(input logic [63:0] st, input logic inv,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_state = st;
    in_inv   = inv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = ~st;
    in_inv   = ~inv;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_state;
  endtask

  typedef struct {
    logic [63:0] st;
    logic        inv;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs [7];
  logic [63:0] res, held;
  int          lat;
  int          lat_s [5];
  logic [63:0] res_s [5];
  logic [63:0] rnd;
  int          seen;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712};
    vecs[1] = '{64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF};
    vecs[2] = '{64'hCCCCCCCCCCCCCCCC, 1'b1, 64'h0000000000000000};
    vecs[3] = '{64'h0000000000000000, 1'b0, 64'hCCCCCCCCCCCCCCCC};
    vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2222222222222222};
    vecs[5] = '{64'hFEDCBA9876543210, 1'b0, 64'h21748FE3DA09B65C};
    vecs[6] = '{64'hFEDCBA9876543210, 1'b1, 64'hA970364BD21C8FE5};

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_state = '0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_inv = 1'b0; sw_state = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_state", out_state, 64'd0);

    foreach (vecs[v]) begin
      run_op(vecs[v].st, vecs[v].inv, res, lat);
      chk($sformatf("vec%0d_state", v), res, vecs[v].exp);
      chk($sformatf("vec%0d_latency", v), 64'(lat), 64'd4);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid_drop", v), 64'(out_valid), 64'd0);
      chk($sformatf("vec%0d_ready_back", v), 64'(in_ready), 64'd1);
    end

    // Back-pressure: result held, no new accept while pending.
    out_ready = 1'b0;
    run_op(64'h0123456789ABCDEF, 1'b0, held, lat);
    chk("bp_state", held, 64'hC56B90AD3EF84712);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_state = 64'h1111111111111111;
      chk("bp_stable", out_state, held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handoff_valid", 64'(out_valid), 64'd0);
    chk("bp_handoff_state", out_state, held);
    chk("bp_idle", 64'(in_ready), 64'd1);

    // Mode toggling during BUSY must not affect the latched forward mode.
    @(negedge clk);
    in_valid = 1'b1; in_state = 64'hFFFFFFFFFFFFFFFF; in_inv = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      in_inv = ~in_inv;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("mode_latch_state", out_state, 64'h2222222222222222);
    chk("mode_latch_latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;

    // Reset while the third chunk is being processed.
    @(negedge clk);
    in_valid = 1'b1; in_state = 64'h0123456789ABCDEF; in_inv = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_out_state", out_state, 64'd0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midreset_no_valid", 64'(seen), 64'd0);
    run_op(64'h0, 1'b0, res, lat);
    chk("midreset_next_state", res, 64'hCCCCCCCCCCCCCCCC);
    @(posedge clk);
    #1;

    // NPC sweep against the bench reference model.
    for (int t = 0; t < 4; t++) begin
      rnd = {$urandom, $urandom};
      @(negedge clk);
      sw_valid = 1'b1; sw_state = rnd; sw_inv = t[0];
      @(posedge clk);
      #1;
      sw_valid = 1'b0; sw_state = ~rnd; sw_inv = ~t[0];
      for (int g = 0; g < 5; g++) lat_s[g] = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        @(posedge clk);
        #1;
        for (int g = 0; g < 5; g++) begin
          if (sw_ov[g] && lat_s[g] < 0) begin
            lat_s[g] = cyc;
            res_s[g] = sw_os[g];
          end
        end
      end
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("sweep%0d_npc%0d_latency", t, 1 << g), 64'(lat_s[g]), 64'(16 >> g));
        chk($sformatf("sweep%0d_npc%0d_state", t, 1 << g), res_s[g], ref_layer(rnd, t[0]));
        chk($sformatf("sweep%0d_npc%0d_ready", t, 1 << g), 64'(sw_ir[g]), 64'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
